// File: rtl/regbank_arbiter.sv
// Register bank shared by NUM_REQ writers through a round-robin arbiter with
// burst lock, plus one registered read port.
module regbank_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      locked,
  output logic [OWN_W-1:0]          owner
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [OWN_W:0]  NREQ_L  = (OWN_W+1)'(NUM_REQ);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx);
    logic [OWN_W:0] s;
    s = {1'b0, idx} + (OWN_W+1)'(1);
    if (s >= NREQ_L) s = s - NREQ_L;
    return s[OWN_W-1:0];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [WIDTH-1:0]  data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = wr_data[i*WIDTH +: WIDTH];
  end

  state_t            state_q, state_d;
  logic [OWN_W-1:0]  ptr_q, ptr_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0]  bank_q [DEPTH];
  logic [WIDTH-1:0]  bank_d [DEPTH];
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0] gnt_c;
  logic               hit;
  logic [OWN_W-1:0]   win;
  logic [OWN_W-1:0]   cand;
  logic [ADDR_W-1:0]  wr_idx;

  // Arbitration and FSM next state; a reset cycle suppresses any grant.
  always_comb begin
    gnt_c   = '0;
    hit     = 1'b0;
    win     = ptr_q;
    cand    = ptr_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    if (state_q == ST_ARB) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!hit && req[cand]) begin
          hit = 1'b1;
          win = cand;
        end
        cand = next_idx(cand);
      end
    end else if (req[owner_q]) begin
      hit = 1'b1;
      win = owner_q;
    end

    if (!rst) hit = 1'b0;

    if (hit) begin
      gnt_c[win] = 1'b1;
      if (state_q == ST_ARB) begin
        ptr_d = next_idx(win);
        if (lock[win]) begin
          state_d = ST_LOCK;
          owner_d = win;
        end
      end else if (!lock[win]) begin
        state_d = ST_ARB;
        ptr_d   = next_idx(win);
        owner_d = '0;
      end
    end
  end

  // Read samples the pre-write bank, giving read-before-write on collisions.
  always_comb begin
    bank_d = bank_q;
    wr_idx = addr_a[win];
    if (hit && addr_ok(wr_idx)) bank_d[wr_idx] = data_a[win];
    rd_data_d = '0;
    if (addr_ok(rd_addr)) rd_data_d = bank_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      rd_data_q <= '0;
      for (int d = 0; d < DEPTH; d++) bank_q[d] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      rd_data_q <= rd_data_d;
      bank_q    <= bank_d;
    end
  end

  assign gnt     = gnt_c;
  assign rd_data = rd_data_q;
  assign locked  = (state_q == ST_LOCK);
  assign owner   = owner_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed table and sequences plus random traffic,
// all compared against an integer-level reference model of the bank and arbiter.
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, lock, gnt;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0] rd_addr, owner;
  logic [7:0] rd_data;
  logic       locked;

  regbank_arbiter #(.WIDTH(8), .NUM_REQ(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt),
    .rd_addr(rd_addr), .rd_data(rd_data), .locked(locked), .owner(owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_bank [4];
  int m_rd;
  int m_ptr;
  bit m_lk;
  int m_own;

  int         last_g;
  logic [3:0] last_gnt;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] exp_gnt;
  } vec_t;
  vec_t rr_tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = 0;
    m_rd = 0; m_ptr = 0; m_lk = 0; m_own = 0;
  endtask

  function automatic int model_pick();
    if (!rst) return -1;
    if (m_lk) return req[m_own] ? m_own : -1;
    for (int k = 0; k < 4; k++) begin
      int r;
      r = (m_ptr + k) % 4;
      if (req[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    int a;
    if (!rst) begin
      model_reset();
      return;
    end
    m_rd = (int'(rd_addr) < 4) ? m_bank[rd_addr] : 0;
    if (g >= 0) begin
      a = int'(wr_addr[g*2 +: 2]);
      if (a < 4) m_bank[a] = int'(wr_data[g*8 +: 8]);
      if (!m_lk) begin
        m_ptr = (g + 1) % 4;
        if (lock[g]) begin
          m_lk  = 1;
          m_own = g;
        end
      end else if (!lock[g]) begin
        m_lk  = 0;
        m_ptr = (g + 1) % 4;
        m_own = 0;
      end
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance it.
  task automatic step();
    int g;
    logic [3:0] eg;
    @(negedge clk);
    g  = model_pick();
    eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("gnt", gnt, eg);
    chk("rd_data", rd_data, m_rd);
    chk("locked", locked, m_lk);
    chk("owner", owner, m_own);
    last_g   = g;
    last_gnt = gnt;
    model_update(g);
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic r, input logic l,
                        input logic [1:0] a, input logic [7:0] d);
    req[i]          = r;
    lock[i]         = l;
    wr_addr[i*2 +: 2] = a;
    wr_data[i*8 +: 8] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    step();
    chk(name, rd_data, exp);
  endtask

  task automatic rand_req(input int i);
    if ($urandom_range(0, 1) == 1)
      set_rq(i, 1'b1, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)));
    else
      set_rq(i, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    rr_tab[0] = '{4'b1111, 4'b0000, 4'b0001};
    rr_tab[1] = '{4'b1111, 4'b0000, 4'b0010};
    rr_tab[2] = '{4'b1111, 4'b0000, 4'b0100};
    rr_tab[3] = '{4'b1111, 4'b0000, 4'b1000};
    rr_tab[4] = '{4'b1111, 4'b0000, 4'b0001};
    rr_tab[5] = '{4'b1111, 4'b0000, 4'b0010};
    rr_tab[6] = '{4'b1111, 4'b0000, 4'b0100};
    rr_tab[7] = '{4'b1111, 4'b0000, 4'b1000};

    rst = 1'b0; req = '0; lock = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(posedge clk); #1;
    model_reset();

    // Reset clears the bank and forces gnt low
    req = 4'b1111;
    step();
    chk("rst_gnt0", last_gnt, 4'b0000);
    rst = 1'b1;
    clear_all();
    set_rq(0, 1'b1, 1'b0, 2'd2, 8'hA5);
    step();
    chk("wr_a5_gnt", last_gnt, 4'b0001);
    rst = 1'b0;
    step();
    chk("rst_forced_gnt", last_gnt, 4'b0000);
    chk("rst_locked", locked, 1'b0);
    rst = 1'b1;
    clear_all();
    read_chk("rst_bank2", 2'd2, 8'h00);

    // Round-robin table
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 1'b0, 1'b0, 2'(i), 8'hB0 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      if (k == 4) for (int i = 0; i < 4; i++) wr_data[i*8 +: 8] = 8'hD0 + 8'(i);
      req  = rr_tab[k].req;
      lock = rr_tab[k].lock;
      step();
      chk($sformatf("rr_gnt%0d", k), last_gnt, rr_tab[k].exp_gnt);
    end
    clear_all();
    for (int i = 0; i < 4; i++) read_chk($sformatf("rr_bank%0d", i), 2'(i), 8'hD0 + 8'(i));

    // Lock burst by requester 1 while all others request
    do_reset();
    set_rq(0, 1'b1, 1'b0, 2'd3, 8'hEE);
    step();
    set_rq(0, 1'b1, 1'b0, 2'd3, 8'h01);
    set_rq(2, 1'b1, 1'b0, 2'd3, 8'h02);
    set_rq(3, 1'b1, 1'b0, 2'd3, 8'h03);
    set_rq(1, 1'b1, 1'b1, 2'd0, 8'h11);
    step();
    chk("burst_g1", last_gnt, 4'b0010);
    chk("burst_locked", locked, 1'b1);
    chk("burst_owner", owner, 2'd1);
    set_rq(1, 1'b1, 1'b1, 2'd1, 8'h22);
    step();
    chk("burst_g2", last_gnt, 4'b0010);
    set_rq(1, 1'b1, 1'b0, 2'd2, 8'h33);
    step();
    chk("burst_g3", last_gnt, 4'b0010);
    chk("burst_unlocked", locked, 1'b0);
    set_rq(1, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    chk("burst_next", last_gnt, 4'b0100);
    set_rq(2, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    chk("burst_next3", last_gnt, 4'b1000);
    set_rq(3, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    chk("burst_next0", last_gnt, 4'b0001);
    clear_all();
    read_chk("burst_bank0", 2'd0, 8'h11);
    read_chk("burst_bank1", 2'd1, 8'h22);
    read_chk("burst_bank2", 2'd2, 8'h33);

    // Owner stalls mid-burst
    do_reset();
    set_rq(0, 1'b1, 1'b1, 2'd0, 8'h77);
    step();
    chk("stall_grant", last_gnt, 4'b0001);
    set_rq(0, 1'b0, 1'b0, 2'd0, 8'h00);
    set_rq(1, 1'b1, 1'b0, 2'd1, 8'hA1);
    set_rq(2, 1'b1, 1'b0, 2'd2, 8'hA2);
    set_rq(3, 1'b1, 1'b0, 2'd3, 8'hA3);
    rd_addr = 2'd1;
    for (int s = 0; s < 2; s++) begin
      step();
      chk($sformatf("stall_gnt%0d", s), last_gnt, 4'b0000);
      chk($sformatf("stall_locked%0d", s), locked, 1'b1);
      chk($sformatf("stall_bank%0d", s), rd_data, 8'h00);
    end
    set_rq(0, 1'b1, 1'b0, 2'd3, 8'h88);
    step();
    chk("stall_final", last_gnt, 4'b0001);
    set_rq(0, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    chk("stall_after", last_gnt, 4'b0010);
    set_rq(1, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    set_rq(2, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    clear_all();

    // Read-before-write collision
    set_rq(0, 1'b1, 1'b0, 2'd3, 8'h3C);
    step();
    set_rq(0, 1'b1, 1'b0, 2'd3, 8'h5A);
    rd_addr = 2'd3;
    step();
    chk("rbw_old", rd_data, 8'h3C);
    clear_all();
    step();
    chk("rbw_new", rd_data, 8'h5A);

    // Reset while requester 2 holds the lock
    do_reset();
    set_rq(2, 1'b1, 1'b1, 2'd1, 8'h99);
    step();
    chk("rl_owner", owner, 2'd2);
    set_rq(2, 1'b1, 1'b1, 2'd1, 8'h9A);
    set_rq(1, 1'b1, 1'b0, 2'd0, 8'h55);
    set_rq(3, 1'b1, 1'b0, 2'd3, 8'h66);
    rst = 1'b0;
    step();
    chk("rl_gnt0", last_gnt, 4'b0000);
    chk("rl_locked", locked, 1'b0);
    rst = 1'b1;
    rd_addr = 2'd1;
    step();
    chk("rl_first", last_gnt, 4'b0010);
    chk("rl_nowrite", rd_data, 8'h00);
    set_rq(1, 1'b0, 1'b0, 2'd0, 8'h00);
    set_rq(2, 1'b1, 1'b0, 2'd1, 8'h9A);
    step();
    set_rq(2, 1'b0, 1'b0, 2'd0, 8'h00);
    step();
    clear_all();

    // Random traffic honouring the hold-until-granted handshake
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 63) != 0);
      rd_addr = 2'($urandom_range(0, 3));
      step();
      for (int i = 0; i < 4; i++) begin
        if (i == last_g) rand_req(i);
        else if (!req[i] && $urandom_range(0, 2) == 0) rand_req(i);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
